picobus_uart_tx: RTL and testbench
==================================

Name: picobus_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a responder on the picorv32 native memory bus (mem_valid/mem_ready).
- Sits beside the SoC RAM and UART on the core's bus and decodes its own 16-byte window.
- Buffers CPU writes in a TX FIFO and serialises them as 8N1 frames on ser_tx.
- Gives firmware non-blocking status, a programmable divider and an empty interrupt.

Parameters:
- BASE_ADDR, 32'h3000_0000: word-aligned base of the 16-byte register window.
- DEFAULT_DIV, 54: reset value of the divider, in clk cycles per bit (50 MHz / 921600).
- FIFO_AW, 4: FIFO address width; depth is 2**FIFO_AW = 16 bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high; all state clears immediately
- mem_valid  in  1  bus request valid
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 means read
- mem_ready  out  1  one-cycle acknowledge
- mem_rdata  out  32  read data, valid while mem_ready=1, otherwise 0
- ser_tx  out  1  serial output, idles high
- irq_empty  out  1  level: FIFO empty and shifter idle

Behaviour:
Reset values:
- mem_ready=0, mem_rdata=0, ser_tx=1, irq_empty=1.
- FIFO empty, div=DEFAULT_DIV, transmitter IDLE.

Decode:
- sel = mem_valid && mem_addr[31:4]==BASE_ADDR[31:4].
- Offset is mem_addr[3:2]:
  - 0 DATA: W pushes wdata[7:0]; R returns 0.
  - 1 DIV: R/W, byte-strobed.
  - 2 STATUS: R only. bit0 busy, bit1 full, bit2 empty, bits[FIFO_AW+8:8] count.
  - 3: reads 0, writes ignored.

Handshake:
- mem_ready and mem_rdata are registered.
- Ack in cycle N+1 for a request presented in cycle N, provided the access can complete in cycle N.
- Ack lasts exactly one cycle.
- A request is not re-acked while mem_ready=1; the condition is sel && !mem_ready.
- DATA write with FIFO full: stall, holding mem_ready=0 until space. The push and the ack happen together.
- A DATA write needs only wstrb[0]. A write with wstrb[0]=0 acks without pushing.
- The block never acks when sel=0, so other slaves own those addresses.

FIFO:
- Occupancy counter has width FIFO_AW+1 so that full is distinguishable.
- Pointers wrap modulo depth.
- Push and pop in the same cycle keep count unchanged and are legal even when full (pop frees a slot first).
- Pop on empty never occurs; the TX FSM only pops when not empty.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: ser_tx=1. If FIFO not empty: pop into shift reg, latch div into bit_div, go to START.
- START: ser_tx=0 for bit_div cycles.
- DATA: 8 bits LSB first, bit_div cycles each, bit counter 0..7.
- STOP: ser_tx=1 for bit_div cycles, then IDLE.
- Effective bit_div = max(div,1).
- Back-to-back frames: a new frame's START begins the cycle after STOP ends, with no extra idle.
- A DIV write mid-frame takes effect on the next frame only.
- busy = state!=IDLE.
- irq_empty = empty && !busy.
- Reset mid-frame: ser_tx returns to 1 asynchronously and the FIFO contents are discarded.

Decomposition:
- Package picobus_uart_pkg:
  - register offset constants REG_DATA/REG_DIV/REG_STATUS;
  - STATUS bit indices;
  - tx_state_t enum.
- Sub-module sync_fifo (params DW=8, AW): push/pop/full/empty/count, async active-high reset.
- Top holds the decode, handshake, divider register and TX FSM.

Test Plan:
- Reset, then read STATUS at BASE+8 -> ack exactly 1 cycle after valid, rdata=32'h0000_0004 (empty); ser_tx=1; irq_empty=1.
- DIV=4, write DATA 8'hA5 -> ser_tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; irq_empty falls and then rises at end of STOP.
- DIV=2, 17 back-to-back DATA writes -> the 17th stalls (mem_ready=0) until the first pop, then acks; frames are contiguous with no idle gaps; the output byte sequence matches the input.
- Write DIV=8 during frame 1 with 2 bytes queued at DIV=4 -> frame 1 bits are 4 cycles, frame 2 bits are 8 cycles.
- DIV write with wstrb=4'b0001, wdata=32'hFFFF_FF10, div previously 54 -> DIV reads 32'h0000_0010; an access at BASE+32'h10 gets no ack from this block.
- Assert rst mid-DATA-bit with 3 bytes queued -> ser_tx=1 immediately; after release STATUS=32'h0000_0004 and no further frames are sent.

Source files
------------

// File: rtl/picobus_uart_pkg.sv
// Shared register map, status bit positions and TX state encoding for the
// picobus UART transmitter.
package picobus_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_DIV    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_EMPTY     = 2;
    localparam int unsigned STAT_COUNT_LSB = 8;

    localparam int unsigned DIV_W = 32;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // A divider of zero would never finish a bit, so it is treated as one.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

endpackage

// File: rtl/picobus_uart_tx_fifo.sv
// Single-clock FIFO with occupancy count; full/empty/count are registered,
// read data is the combinational head-of-queue word.
module sync_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata_c,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count_nxt;

    // A pop frees a slot first, so push+pop is accepted even when full.
    always_comb begin
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata_c = mem[rd_ptr];

endmodule

// File: rtl/picobus_uart_tx.sv
// picorv32 native-bus responder: 16-byte register window, TX FIFO and an
// 8N1 serialiser with programmable bit divider and empty interrupt.
module picobus_uart_tx
    import picobus_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned DEFAULT_DIV = 54,
    parameter int unsigned FIFO_AW     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        ser_tx,
    output logic        irq_empty
);

    localparam int unsigned CW = FIFO_AW + 1;

    tx_state_t        state;
    tx_state_t        state_n;
    logic [7:0]       shift;
    logic [7:0]       shift_n;
    logic [DIV_W-1:0] bit_div;
    logic [DIV_W-1:0] bit_div_n;
    logic [DIV_W-1:0] tick;
    logic [DIV_W-1:0] tick_n;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_n;
    logic             tick_end;
    logic             ser_tx_n;

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_n;
    logic             mem_ready_n;
    logic [31:0]      mem_rdata_n;
    logic             irq_empty_n;

    logic             sel;
    logic [1:0]       offset;
    logic             is_write;
    logic             push_req;
    logic             stall;
    logic             busy;
    logic [31:0]      status;
    logic [CW-1:0]    count_n;

    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    logic             unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, mem_addr[1:0]};

    sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wdata   (mem_wdata[7:0]),
        .pop     (fifo_pop),
        .rdata_c (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // TX next-state: STOP chains straight into the next START when data waits.
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_div_n = bit_div;
        tick_n    = tick;
        bit_cnt_n = bit_cnt;
        fifo_pop  = 1'b0;
        tick_end  = (tick == bit_div - DIV_W'(1));
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_n   = fifo_rdata;
                    bit_div_n = eff_div(div);
                    tick_n    = '0;
                    state_n   = TX_START;
                end
            end
            TX_START: begin
                if (tick_end) begin
                    tick_n    = '0;
                    bit_cnt_n = '0;
                    state_n   = TX_DATA;
                end else begin
                    tick_n = tick + DIV_W'(1);
                end
            end
            TX_DATA: begin
                if (tick_end) begin
                    tick_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = TX_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        shift_n   = {1'b0, shift[7:1]};
                    end
                end else begin
                    tick_n = tick + DIV_W'(1);
                end
            end
            TX_STOP: begin
                if (tick_end) begin
                    tick_n = '0;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_n   = fifo_rdata;
                        bit_div_n = eff_div(div);
                        state_n   = TX_START;
                    end else begin
                        state_n = TX_IDLE;
                    end
                end else begin
                    tick_n = tick + DIV_W'(1);
                end
            end
            default: state_n = TX_IDLE;
        endcase

        case (state_n)
            TX_START: ser_tx_n = 1'b0;
            TX_DATA:  ser_tx_n = shift_n[0];
            default:  ser_tx_n = 1'b1;
        endcase
    end

    // Bus decode and handshake; a DATA push into a full FIFO waits for a pop.
    always_comb begin
        sel         = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
        offset      = mem_addr[3:2];
        is_write    = |mem_wstrb;
        push_req    = sel && !mem_ready && is_write && (offset == REG_DATA) && mem_wstrb[0];
        stall       = push_req && fifo_full && !fifo_pop;
        fifo_push   = push_req && !stall;
        mem_ready_n = sel && !mem_ready && !stall;
        busy        = (state != TX_IDLE);

        status                           = '0;
        status[STAT_BUSY]                = busy;
        status[STAT_FULL]                = fifo_full;
        status[STAT_EMPTY]               = fifo_empty;
        status[STAT_COUNT_LSB +: CW]     = fifo_count;

        div_n       = div;
        mem_rdata_n = '0;
        if (mem_ready_n) begin
            if (is_write) begin
                if (offset == REG_DIV) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_wstrb[b]) div_n[8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end
            end else begin
                case (offset)
                    REG_DIV:    mem_rdata_n = div;
                    REG_STATUS: mem_rdata_n = status;
                    default:    mem_rdata_n = '0;
                endcase
            end
        end

        count_n     = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        irq_empty_n = (count_n == '0) && (state_n == TX_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= TX_IDLE;
            shift     <= '0;
            bit_div   <= DIV_W'(DEFAULT_DIV);
            tick      <= '0;
            bit_cnt   <= '0;
            div       <= DIV_W'(DEFAULT_DIV);
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            ser_tx    <= 1'b1;
            irq_empty <= 1'b1;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            bit_div   <= bit_div_n;
            tick      <= tick_n;
            bit_cnt   <= bit_cnt_n;
            div       <= div_n;
            mem_ready <= mem_ready_n;
            mem_rdata <= mem_rdata_n;
            ser_tx    <= ser_tx_n;
            irq_empty <= irq_empty_n;
        end
    end

endmodule

// File: tb/tb_picobus_uart_tx.sv
// Directed bench for picobus_uart_tx: bus tasks drive the register window,
// a serial monitor checks every line cycle against a byte scoreboard.
module tb_picobus_uart_tx;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ser_tx;
    logic        irq_empty;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  byte_q[$];
    logic [31:0] model_div_reg;
    bit          contig_chk;
    int          frames_done = 0;
    int          last_frame_div = 0;
    logic        last_irq_stop = 1'b1;
    int          cyc = 0;

    bit          mon_active = 0;
    int          mon_cnt;
    int          mon_div;
    logic [7:0]  mon_byte;
    int          idle_run = 0;
    int          bi;
    logic        exp_bit;

    picobus_uart_tx #(
        .BASE_ADDR   (BASE),
        .DEFAULT_DIV (54),
        .FIFO_AW     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ser_tx    (ser_tx),
        .irq_empty (irq_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus transfer; lat = edges until ack, -1 if no ack within budget.
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                       input int budget, output logic [31:0] rdata, output int lat);
        if (mem_ready) idle(1);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        lat       = 0;
        rdata     = '0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!mem_ready && lat < budget);
        if (mem_ready) rdata = mem_rdata;
        else           lat   = -1;
        mem_valid = 1'b0;
        mem_wstrb = '0;
        mem_addr  = '0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      output int lat);
        logic [31:0] r;
        bus(addr, data, strb, 5000, r, lat);
        if (lat > 0 && addr[31:4] == BASE[31:4]) begin
            if (addr[3:2] == 2'd0 && strb[0]) begin
                byte_q.push_back(data[7:0]);
            end else if (addr[3:2] == 2'd1) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model_div_reg[8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output int lat);
        bus(addr, 32'h0, 4'h0, 20, data, lat);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (frames_done < n && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("frames_done", 32'(frames_done), 32'(n));
    endtask

    // Serial monitor: each frame must match the scoreboard head bit-for-bit.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 0;
                idle_run   = 0;
            end else begin
                if (!mon_active) begin
                    if (ser_tx === 1'b0) begin
                        chk("frame_expected", 32'(byte_q.size() != 0), 32'(1));
                        mon_byte = (byte_q.size() != 0) ? byte_q.pop_front() : 8'h00;
                        if (contig_chk) chk("frame_gap", 32'(idle_run), 32'(0));
                        mon_div    = (model_div_reg == 0) ? 1 : int'(model_div_reg);
                        mon_cnt    = 0;
                        mon_active = 1;
                    end else begin
                        idle_run++;
                    end
                end
                if (mon_active) begin
                    bi      = mon_cnt / mon_div;
                    exp_bit = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : mon_byte[bi-1];
                    chk("ser_tx_bit", 32'(ser_tx), 32'(exp_bit));
                    mon_cnt++;
                    if (mon_cnt == 10 * mon_div) begin
                        mon_active     = 0;
                        frames_done++;
                        last_frame_div = mon_div;
                        last_irq_stop  = irq_empty;
                        idle_run       = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] r;
        int lat;
        int c0;
        int fd;

        rst           = 1'b1;
        mem_valid     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wstrb     = '0;
        model_div_reg = 32'd54;
        contig_chk    = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ser_tx",    32'(ser_tx),    32'(1));
        chk("rst_irq_empty", 32'(irq_empty), 32'(1));
        chk("rst_mem_ready", 32'(mem_ready), 32'(0));
        chk("rst_mem_rdata", mem_rdata,      32'h0);
        rst = 1'b0;
        idle(1);

        // Status after reset, single-cycle ack.
        rd(BASE + 32'h8, r, lat);
        chk("status_lat", 32'(lat), 32'(1));
        chk("status_reset", r, 32'h0000_0004);
        chk("idle_ser_tx", 32'(ser_tx), 32'(1));
        chk("idle_irq", 32'(irq_empty), 32'(1));

        // Divider byte strobes, decode window and read-as-zero offsets.
        rd(BASE + 32'h4, r, lat);
        chk("div_reset", r, 32'h0000_0036);
        wr(BASE + 32'h4, 32'hFFFF_FF10, 4'b0001, lat);
        chk("div_wr_lat", 32'(lat), 32'(1));
        rd(BASE + 32'h4, r, lat);
        chk("div_byte0", r, 32'h0000_0010);
        bus(BASE + 32'h10, 32'h0, 4'h0, 8, r, lat);
        chk("stray_read", 32'(lat), 32'hFFFF_FFFF);
        bus(BASE + 32'h14, 32'h55, 4'hF, 8, r, lat);
        chk("stray_write", 32'(lat), 32'hFFFF_FFFF);
        rd(BASE + 32'h0, r, lat);
        chk("data_read_zero", r, 32'h0);
        rd(BASE + 32'hC, r, lat);
        chk("reg3_read_zero", r, 32'h0);
        wr(BASE + 32'h0, 32'h5A, 4'b0010, lat);
        chk("data_nostrb_lat", 32'(lat), 32'(1));
        idle(30);
        rd(BASE + 32'h8, r, lat);
        chk("status_no_push", r, 32'h0000_0004);
        chk("no_frames", 32'(frames_done), 32'(0));

        // Single frame at DIV=4 with interrupt edges.
        wr(BASE + 32'h4, 32'd4, 4'hF, lat);
        wr(BASE + 32'h0, 32'hA5, 4'h1, lat);
        chk("a5_lat", 32'(lat), 32'(1));
        chk("irq_falls", 32'(irq_empty), 32'(0));
        wait_frames(1, 200);
        chk("irq_low_in_stop", 32'(last_irq_stop), 32'(0));
        chk("irq_rises", 32'(irq_empty), 32'(1));
        chk("ser_tx_idle", 32'(ser_tx), 32'(1));
        rd(BASE + 32'h8, r, lat);
        chk("status_after_a5", r, 32'h0000_0004);

        // Divider change mid-frame applies to the next frame only.
        wr(BASE + 32'h0, 32'h3C, 4'h1, lat);
        wr(BASE + 32'h0, 32'hC3, 4'h1, lat);
        idle(10);
        wr(BASE + 32'h4, 32'd8, 4'hF, lat);
        wait_frames(3, 400);
        chk("frame2_div", 32'(last_frame_div), 32'(8));

        // Fill the FIFO behind a slow frame; the next push stalls until the pop.
        wr(BASE + 32'h4, 32'd100, 4'hF, lat);
        wr(BASE + 32'h0, 32'h81, 4'h1, lat);
        c0 = cyc;
        wr(BASE + 32'h4, 32'd2, 4'hF, lat);
        for (int i = 1; i <= 16; i++) begin
            wr(BASE + 32'h0, 32'((i * 37 + 5) & 8'hFF), 4'h1, lat);
            chk("burst_lat", 32'(lat), 32'(1));
        end
        rd(BASE + 32'h8, r, lat);
        chk("status_full", r, 32'h0000_1003);
        wr(BASE + 32'h0, 32'hE7, 4'h1, lat);
        chk("stall_ack_cycle", 32'(cyc - c0), 32'(1001));
        contig_chk = 1;
        wait_frames(21, 3000);
        contig_chk = 0;
        chk("queue_drained", 32'(byte_q.size()), 32'(0));

        // Reset in the middle of a data bit with bytes still queued.
        wr(BASE + 32'h4, 32'd4, 4'hF, lat);
        wr(BASE + 32'h0, 32'h00, 4'h1, lat);
        wr(BASE + 32'h0, 32'h11, 4'h1, lat);
        wr(BASE + 32'h0, 32'h22, 4'h1, lat);
        idle(3);
        chk("pre_reset_low", 32'(ser_tx), 32'(0));
        rst = 1'b1;
        #1;
        chk("async_rst_ser_tx", 32'(ser_tx), 32'(1));
        chk("async_rst_irq", 32'(irq_empty), 32'(1));
        byte_q.delete();
        model_div_reg = 32'd54;
        idle(2);
        rst = 1'b0;
        idle(1);
        rd(BASE + 32'h8, r, lat);
        chk("status_post_rst", r, 32'h0000_0004);
        rd(BASE + 32'h4, r, lat);
        chk("div_post_rst", r, 32'h0000_0036);
        fd = frames_done;
        idle(300);
        chk("no_frames_post_rst", 32'(frames_done), 32'(fd));
        chk("ser_tx_post_rst", 32'(ser_tx), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
